// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: Diff = A - B - Bin, LSB first, one bit per clock.
// A single borrow flop carries between bits; results commit with a one-cycle done pulse.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             V
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             a_msb;
    logic             b_msb;

    logic             d;
    logic             w_next;
    logic [WIDTH-1:0] res_next;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        d        = 1'b0;
        w_next   = 1'b0;
        res_next = res_sh;
        d        = a_sh[0] ^ b_sh[0] ^ borrow;
        w_next   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
        res_next = {d, res_sh[WIDTH-1:1]};
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            Diff   <= '0;
            Bout   <= 1'b0;
            V      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh   <= A;
                        b_sh   <= B;
                        res_sh <= '0;
                        borrow <= Bin;
                        cnt    <= '0;
                        // The shifters lose the MSBs, so keep them for the overflow term.
                        a_msb  <= A[WIDTH-1];
                        b_msb  <= B[WIDTH-1];
                        state  <= SHIFT;
                        busy   <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    borrow <= w_next;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        Diff  <= res_next;
                        Bout  <= w_next;
                        V     <= (a_msb != b_msb) & (d != a_msb);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing Diff = A − B − Bin one bit per clock, LSB first, with a single borrow flip-flop. It is the inverse-direction companion to the team's combinational full adder and serves area-constrained datapaths that trade latency for gate count. Operands are captured on a start handshake, and the result is reported with a one-cycle done pulse.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2 to 32.

- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while busy=0.
- A  input  WIDTH  minuend; captured when start is accepted.
- B  input  WIDTH  subtrahend; captured when start is accepted.
- Bin  input  1  borrow-in; captured when start is accepted.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when a result is committed.
- Diff  output  WIDTH  difference; holds the last committed result.
- Bout  output  1  borrow-out of the MSB; holds the last committed value.
- V  output  1  signed overflow of the last committed result.

## Operation
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1.
  - DONE: done=1, busy=0.
- Accept: start=1 at a rising edge while in IDLE or DONE.
  - Capture A, B and Bin into internal shift registers.
  - Load the borrow flop with Bin and clear the bit counter.
  - Go to SHIFT.
- start is ignored while in SHIFT. No queuing.
- Each SHIFT edge processes one bit, with a = a_sh[0], b = b_sh[0], w = borrow flop:
  - d = a ^ b ^ w
  - w_next = (~a & b) | (~(a ^ b) & w)
  - Shift d into the MSB of the result shift register.
  - Shift a_sh and b_sh right.
  - Increment the counter.
- After the edge that processes bit WIDTH−1, go to DONE and commit in that same edge:
  - Diff gets the completed result register.
  - Bout gets w_next.
  - V = (A[MSB] != B[MSB]) & (Diff[MSB] != A[MSB]), using the captured operands.
- DONE lasts exactly one cycle. The next state is SHIFT if start=1, otherwise IDLE.
- Diff, Bout and V change only on commit. Intermediate shift contents are never visible on them.
- Arithmetic is modulo 2^WIDTH. Bout=1 exactly when A < B + Bin, compared as unsigned.
- Reset (rst_n=0, any state, immediately):
  - Outputs: busy=0, done=0, Diff=0, Bout=0, V=0.
  - Internal: state=IDLE, internal registers cleared.
  - An operation interrupted by reset produces no done and no commit.

## Timing
- Let start be sampled at edge E0.
  - busy is high after E0 through edge E(WIDTH).
  - Bits are processed at edges E1 through E(WIDTH).
  - After E(WIDTH): done=1, busy=0, and Diff/Bout/V are valid.
  - After E(WIDTH+1): done=0, unless the previous op ended and a new one completes at that edge, which is not possible for WIDTH≥2.
- Latency is WIDTH+1 edges from the accepting edge to done high.
- Back-to-back throughput is one result per WIDTH+1 cycles, with start held or asserted during the DONE cycle.
- A, B and Bin may change freely after the accepting edge.
- Reset release: the first edge with rst_n=1 may accept start.

## Test plan
- WIDTH=8, A=0x5A, B=0x23, Bin=0, start one cycle:
  - busy high for 8 cycles, then done for 1 cycle.
  - Diff=0x37, Bout=0, V=0.
- A=0x00, B=0x01, Bin=0 -> Diff=0xFF, Bout=1, V=0.
- Overflow and borrow-in:
  - A=0x80, B=0x01, Bin=0 -> Diff=0x7F, Bout=0, V=1.
  - A=0x10, B=0x0F, Bin=1 -> Diff=0x00, Bout=0, V=0.
- start held high continuously with A=0x05, B=0x07:
  - done every 9 cycles, Diff=0xFE, Bout=1 each time.
  - Re-assert start (or change operands) during busy: ignored; the result still reflects the captured values.
- Reset mid-operation:
  - Run A=0xFF, B=0x01, then pull rst_n low at the 3rd SHIFT cycle.
  - Immediately: busy=0, Diff=0, Bout=0, V=0, and no done pulse.
  - After release, A=0x03, B=0x03, Bin=0 -> Diff=0x00, Bout=0.
